// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial adder controller, one full-adder slice over WIDTH cycles
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] s_sh_q, s_sh_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cy_q, cy_d;
  logic             c_out_q, c_out_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             s_bit, c_bit;

  assign s_bit = a_sh_q[0] ^ b_sh_q[0] ^ cy_q;
  assign c_bit = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & cy_q) | (b_sh_q[0] & cy_q);

  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    s_sh_d  = s_sh_q;
    sum_d   = sum_q;
    cy_d    = cy_q;
    c_out_d = c_out_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        // DONE exits straight into an accept so a held start yields one op per WIDTH+1 cycles
        state_d = ST_IDLE;
        if (start) begin
          state_d = ST_RUN;
          a_sh_d  = a;
          b_sh_d  = b;
          cy_d    = c_in;
          cnt_d   = '0;
        end
      end
      ST_RUN: begin
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        s_sh_d = {s_bit, s_sh_q[WIDTH-1:1]};
        cy_d   = c_bit;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          sum_d   = {s_bit, s_sh_q[WIDTH-1:1]};
          c_out_d = c_bit;
          cnt_d   = '0;
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      s_sh_q  <= '0;
      sum_q   <= '0;
      cy_q    <= 1'b0;
      c_out_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      s_sh_q  <= s_sh_d;
      sum_q   <= sum_d;
      cy_q    <= cy_d;
      c_out_q <= c_out_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy  = (state_q == ST_RUN);
  assign done  = (state_q == ST_DONE);
  assign sum   = sum_q;
  assign c_out = c_out_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - directed scoreboard bench for serial_add_ctrl
module tb_serial_add_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         c_in = 1'b0;
  logic         busy, done, c_out;
  logic [W-1:0] sum;

  logic [W:0] exp_q[$];
  int vectors = 0;
  int errs = 0;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .c_in(c_in),
    .busy(busy), .done(done), .sum(sum), .c_out(c_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
    return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
  endfunction

  task automatic accept(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
    a = x; b = y; c_in = ci; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    exp_q.push_back(model(x, y, ci));
  endtask

  task automatic pop_chk(input string tag);
    logic [W:0] e;
    if (exp_q.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_sum"}, 32'(sum), 32'(e[W-1:0]));
      chk({tag, "_cout"}, 32'(c_out), 32'(e[W]));
    end
  endtask

  // waits for done after an accept; checks latency and busy length when asked
  task automatic wait_done(input string tag, input bit timing);
    int n = 0;
    int nb = 0;
    bit seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      n++;
      if (busy) nb++;
      if (busy && done) chk({tag, "_busy_done_excl"}, 32'd1, 32'd0);
      if (done) seen = 1;
    end
    if (!seen) begin
      chk({tag, "_timeout"}, 32'd0, 32'd1);
    end else begin
      if (timing) begin
        chk({tag, "_latency"}, 32'(n), 32'(W + 1));
        chk({tag, "_busy_cycles"}, 32'(nb), 32'(W));
      end
      pop_chk(tag);
      @(negedge clk);
      if (timing) chk({tag, "_done_one_cycle"}, 32'(done), 32'd0);
    end
  endtask

  initial begin
    int ndone;
    int done_edge[$];
    logic [W-1:0] sum_at_done;

    #2;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(c_out), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    accept(8'h5A, 8'h3C, 1'b0);
    wait_done("t5a3c", 1'b1);

    accept(8'hFF, 8'h01, 1'b0);
    wait_done("tff01", 1'b0);
    accept(8'hFF, 8'h00, 1'b1);
    wait_done("tff00c", 1'b0);

    // second start during RUN must be ignored
    accept(8'h12, 8'h34, 1'b0);
    a = 8'hFF; b = 8'hFF; c_in = 1'b1;
    @(posedge clk); @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    ndone = 0;
    sum_at_done = '0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        sum_at_done = sum;
        if (ndone == 1) pop_chk("tign");
      end
    end
    chk("tign_done_count", 32'(ndone), 32'd1);
    chk("tign_sum_held", 32'(sum), 32'(sum_at_done));
    chk("tign_idle", 32'(busy), 32'd0);

    // continuous start: accepts at edges 0, 9, 18
    a = 8'h01; b = 8'h01; c_in = 1'b0; start = 1'b1;
    for (int e = 0; e <= 26; e++) begin
      @(posedge clk);
      if (e == 0 || e == 9 || e == 18) exp_q.push_back(model(8'h01, 8'h01, 1'b0));
      @(negedge clk);
      if (e == 9) chk("thold_busy_after_9", 32'(busy), 32'd1);
      if (done) begin
        done_edge.push_back(e);
        pop_chk("thold");
      end
    end
    start = 1'b0;
    chk("thold_ndone", 32'(done_edge.size()), 32'd3);
    for (int k = 0; k < done_edge.size() && k < 3; k++)
      chk("thold_done_edge", 32'(done_edge[k]), 32'(8 + 9 * k));
    @(negedge clk);
    exp_q.delete();

    // mid-run reset discards the operation and clears outputs immediately
    a = 8'hAA; b = 8'h55; c_in = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 0; i < 4; i++) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("trst_busy", 32'(busy), 32'd0);
    chk("trst_done", 32'(done), 32'd0);
    chk("trst_sum", 32'(sum), 32'd0);
    chk("trst_cout", 32'(c_out), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    accept(8'h03, 8'h04, 1'b0);
    wait_done("t0304", 1'b1);

    accept(8'h00, 8'h00, 1'b1);
    wait_done("t0000c", 1'b0);
    accept(8'h80, 8'h80, 1'b0);
    wait_done("t8080", 1'b0);

    for (int i = 0; i < 4; i++) begin
      logic [W-1:0] x, y;
      logic ci;
      x = W'($urandom);
      y = W'($urandom);
      ci = 1'($urandom);
      accept(x, y, ci);
      wait_done("trand", 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
